// File: rtl/population_fitness_scheduler_pkg.sv
// Shared GA definitions: scheduler state encoding and default datapath widths
// used by the population fitness scheduler and its best/total tracker.
package population_fitness_scheduler_pkg;

  localparam int DEFAULT_ERROR_WIDTH       = 6;
  localparam int DEFAULT_INSTRUCTION_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_LAUNCH,
    ST_RUN,
    ST_STORE,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/ga_best_tracker.sv
// Running minimum error (with its index) and running error sum for one
// population run; clear starts a new run, update folds in one score.
module ga_best_tracker #(
  parameter int IndexWidth = 4,
  parameter int ErrorWidth = 6,
  parameter int TotalWidth = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  update,
  input  logic [IndexWidth-1:0] index,
  input  logic [ErrorWidth-1:0] error,
  output logic [IndexWidth-1:0] best_index,
  output logic [ErrorWidth-1:0] best_error,
  output logic [TotalWidth-1:0] total_error
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_index  <= '0;
      best_error  <= '1;
      total_error <= '0;
    end else if (update) begin
      total_error <= total_error + TotalWidth'(error);
      // Strict compare: on a tie the earlier (lower) index is kept.
      if (error < best_error) begin
        best_error <= error;
        best_index <= index;
      end
    end
  end

endmodule

// File: rtl/population_fitness_scheduler.sv
// Walks the population through one shared fitness evaluator: fetch genome,
// launch, wait for finish (under a watchdog), store score, track best/total.
module population_fitness_scheduler
  import population_fitness_scheduler_pkg::*;
#(
  parameter int PopulationSize   = 16,
  parameter int IndexWidth       = $clog2(PopulationSize),
  parameter int InstructionWidth = DEFAULT_INSTRUCTION_WIDTH,
  parameter int ErrorWidth       = DEFAULT_ERROR_WIDTH,
  parameter int TotalWidth       = ErrorWidth + IndexWidth,
  parameter int WatchdogWidth    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        buzy,
  output logic                        done,
  output logic                        fault,
  output logic [IndexWidth-1:0]       pop_addr,
  output logic                        pop_rd,
  input  logic [InstructionWidth-1:0] pop_data,
  output logic [InstructionWidth-1:0] fit_individual,
  output logic                        fit_start,
  input  logic                        fit_buzy,
  input  logic                        fit_finish,
  input  logic [ErrorWidth-1:0]       fit_error,
  output logic                        err_we,
  output logic [IndexWidth-1:0]       err_addr,
  output logic [ErrorWidth-1:0]       err_data,
  output logic [IndexWidth-1:0]       best_index,
  output logic [ErrorWidth-1:0]       best_error,
  output logic [TotalWidth-1:0]       total_error
);

  sched_state_e state, state_next;

  logic [IndexWidth-1:0]    index;
  logic [WatchdogWidth-1:0] watchdog;
  logic [ErrorWidth-1:0]    error_q;
  logic                     wd_expired;
  logic                     last_index;
  logic                     run_clear;

  assign wd_expired = &watchdog;
  assign last_index = (index == IndexWidth'(PopulationSize - 1));
  assign run_clear  = (state == ST_IDLE) && start;

  assign buzy     = (state != ST_IDLE);
  assign pop_addr = index;
  assign err_addr = index;
  assign err_data = error_q;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    pop_rd     = 1'b0;
    fit_start  = 1'b0;
    err_we     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        pop_rd     = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD:  state_next = ST_LAUNCH;
      ST_LAUNCH: begin
        if (wd_expired) begin
          state_next = ST_DONE;
        end else if (!fit_finish) begin
          // Hold off while the previous individual's finish is still high.
          fit_start = 1'b1;
          if (fit_buzy) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wd_expired)      state_next = ST_DONE;
        else if (fit_finish) state_next = ST_STORE;
      end
      ST_STORE: begin
        err_we     = 1'b1;
        state_next = last_index ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      index          <= '0;
      watchdog       <= '0;
      error_q        <= '0;
      fit_individual <= '0;
      fault          <= 1'b0;
    end else begin
      state <= state_next;

      if (run_clear)                    index <= '0;
      else if (state == ST_STORE && !last_index) index <= index + 1'b1;

      if (state == ST_LOAD) begin
        watchdog       <= '0;
        fit_individual <= pop_data;
      end else if (state == ST_LAUNCH || state == ST_RUN) begin
        watchdog <= watchdog + 1'b1;
      end

      if (state == ST_RUN && fit_finish) error_q <= fit_error;

      if (run_clear) fault <= 1'b0;
      else if ((state == ST_LAUNCH || state == ST_RUN) && wd_expired) fault <= 1'b1;
    end
  end

  ga_best_tracker #(
    .IndexWidth(IndexWidth),
    .ErrorWidth(ErrorWidth),
    .TotalWidth(TotalWidth)
  ) u_best_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (run_clear),
    .update     (state == ST_STORE),
    .index      (index),
    .error      (error_q),
    .best_index (best_index),
    .best_error (best_error),
    .total_error(total_error)
  );

endmodule

// File: tb/tb_population_fitness_scheduler.sv
// Bench for population_fitness_scheduler: pop RAM and fitness unit models,
// score-write monitor, table vectors, random runs and corner-case sequences.
module tb_population_fitness_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int GW = 64;
  localparam int EW = 6;
  localparam int TW = EW + IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          buzy, done, fault;
  logic [IW-1:0] pop_addr;
  logic          pop_rd;
  logic [GW-1:0] pop_data;
  logic [GW-1:0] fit_individual;
  logic          fit_start;
  logic          fit_buzy;
  logic          fit_finish;
  logic [EW-1:0] fit_error;
  logic          err_we;
  logic [IW-1:0] err_addr;
  logic [EW-1:0] err_data;
  logic [IW-1:0] best_index;
  logic [EW-1:0] best_error;
  logic [TW-1:0] total_error;

  always #5 clk = ~clk;

  population_fitness_scheduler #(.PopulationSize(N)) dut (
    .clk(clk), .rst(rst), .start(start), .buzy(buzy), .done(done), .fault(fault),
    .pop_addr(pop_addr), .pop_rd(pop_rd), .pop_data(pop_data),
    .fit_individual(fit_individual), .fit_start(fit_start), .fit_buzy(fit_buzy),
    .fit_finish(fit_finish), .fit_error(fit_error), .err_we(err_we),
    .err_addr(err_addr), .err_data(err_data), .best_index(best_index),
    .best_error(best_error), .total_error(total_error)
  );

  // Scenario knobs shared with the models.
  logic [GW-1:0] pop_mem [N];
  logic [EW-1:0] tab [N];
  int            hold;
  int            run_len;
  int            hang_idx;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Population RAM: one-cycle registered read.
  always @(posedge clk) if (pop_rd === 1'b1) pop_data <= pop_mem[pop_addr];

  // Behavioural fitness unit, changes on negedge. The n-th launch since reset
  // scores tab[n % N] and must carry genome pop_mem[n % N].
  logic m_busy, m_hang;
  int   m_cnt, m_fin_cnt, m_n, m_starts, gen_bad;
  initial begin m_starts = 0; gen_bad = 0; end
  assign fit_buzy = m_busy;
  always @(negedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_hang <= 1'b0; fit_finish <= 1'b0; fit_error <= '0; m_n <= 0;
    end else if (m_busy) begin
      if (m_hang) begin
        if (hang_idx < 0) begin m_busy <= 1'b0; m_hang <= 1'b0; m_n <= 0; end
      end else if (m_cnt <= 1) begin
        m_busy <= 1'b0; fit_finish <= 1'b1; m_fin_cnt <= hold;
        fit_error <= tab[(m_n - 1) % N];
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (fit_finish) begin
      if (m_fin_cnt <= 1) fit_finish <= 1'b0;
      else m_fin_cnt <= m_fin_cnt - 1;
    end else if (fit_start === 1'b1) begin
      m_busy   <= 1'b1;
      m_cnt    <= run_len;
      m_hang   <= ((m_n % N) == hang_idx);
      m_starts <= m_starts + 1;
      if (fit_individual !== pop_mem[m_n % N]) gen_bad <= gen_bad + 1;
      m_n <= m_n + 1;
    end
  end

  // Score-RAM write log and launch-while-finish monitors.
  typedef struct packed { logic [IW-1:0] a; logic [EW-1:0] d; } wr_t;
  wr_t sq[$];
  int  viol_p = 0, viol_n = 0;
  always @(posedge clk) begin
    #1;
    if (err_we === 1'b1) sq.push_back('{a: err_addr, d: err_data});
    if (fit_start === 1'b1 && fit_finish === 1'b1) viol_p++;
  end
  always @(negedge clk) begin
    #1;
    if (fit_start === 1'b1 && fit_finish === 1'b1) viol_n++;
  end

  // Reference: best = first index of the minimum of the first k scores,
  // starting from the all-ones sentinel; total = plain sum.
  task automatic ref_result(input int k, output logic [IW-1:0] bi,
                            output logic [EW-1:0] be, output logic [TW-1:0] tot);
    int sum = 0;
    int mn  = (1 << EW) - 1;
    int at  = 0;
    for (int i = 0; i < k; i++) begin
      sum += int'(tab[i]);
      if (int'(tab[i]) < mn) begin mn = int'(tab[i]); at = i; end
    end
    bi = IW'(at); be = EW'(mn); tot = TW'(sum);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (done !== 1'b1 && c < 3000) begin @(negedge clk); c++; end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Called on the negedge where done is high.
  task automatic finish_checks(input string tag, input int base, input int sbase,
                               input int k, input int starts, input logic exp_fault);
    logic [IW-1:0] bi; logic [EW-1:0] be; logic [TW-1:0] tot;
    ref_result(k, bi, be, tot);
    check({tag, "_writes"}, sq.size() - base, k);
    for (int i = 0; i < k; i++) begin
      if (base + i < sq.size()) begin
        check({tag, "_waddr"}, sq[base+i].a, i);
        check({tag, "_wdata"}, sq[base+i].d, tab[i]);
      end
    end
    check({tag, "_starts"}, m_starts - sbase, starts);
    check({tag, "_best_index"}, best_index, bi);
    check({tag, "_best_error"}, best_error, be);
    check({tag, "_total"}, total_error, tot);
    check({tag, "_fault"}, fault, exp_fault);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_buzy_drop"}, buzy, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic fill_pop();
    for (int i = 0; i < N; i++) pop_mem[i] = {$urandom, $urandom};
  endtask

  typedef struct packed {
    logic [N*EW-1:0] errs;   // element i in bits [i*EW +: EW]
    logic [3:0]      hold;
    logic [IW-1:0]   bi;
    logic [EW-1:0]   be;
    logic [TW-1:0]   tot;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base, sbase, c, busy_seen;
    vecs[0] = '{errs: {6'd3,  6'd7,  6'd3,  6'd5 }, hold: 4'd1, bi: 2'd1, be: 6'd3,  tot: 8'd18};
    vecs[1] = '{errs: {6'd0,  6'd0,  6'd0,  6'd0 }, hold: 4'd1, bi: 2'd0, be: 6'd0,  tot: 8'd0};
    vecs[2] = '{errs: {6'd63, 6'd63, 6'd63, 6'd63}, hold: 4'd2, bi: 2'd0, be: 6'd63, tot: 8'd252};
    vecs[3] = '{errs: {6'd2,  6'd7,  6'd8,  6'd9 }, hold: 4'd2, bi: 2'd3, be: 6'd2,  tot: 8'd26};
    vecs[4] = '{errs: {6'd1,  6'd1,  6'd4,  6'd4 }, hold: 4'd6, bi: 2'd2, be: 6'd1,  tot: 8'd10};
    vecs[5] = '{errs: {6'd40, 6'd30, 6'd20, 6'd10}, hold: 4'd1, bi: 2'd0, be: 6'd10, tot: 8'd100};

    rst = 1'b1; start = 1'b0; hold = 1; run_len = 4; hang_idx = -1;
    fill_pop();
    for (int i = 0; i < N; i++) tab[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_buzy", buzy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_pop_rd", pop_rd, 1'b0);
    check("rst_fit_start", fit_start, 1'b0);
    check("rst_err_we", err_we, 1'b0);
    check("rst_fit_individual", fit_individual, '0);
    check("rst_best_index", best_index, '0);
    check("rst_best_error", best_error, 6'h3f);
    check("rst_total", total_error, '0);
    rst = 1'b0;

    // Table vectors with hand-derived expectations.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) tab[i] = vecs[v].errs[i*EW +: EW];
      hold = int'(vecs[v].hold);
      fill_pop();
      base = sq.size(); sbase = m_starts;
      pulse_start();
      wait_done("vec");
      finish_checks("vec", base, sbase, N, N, 1'b0);
      check("vec_tab_best_index", best_index, vecs[v].bi);
      check("vec_tab_best_error", best_error, vecs[v].be);
      check("vec_tab_total", total_error, vecs[v].tot);
    end

    // Randomised runs against the reference.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) tab[i] = EW'($urandom_range(0, 63));
      hold = $urandom_range(1, 3);
      run_len = $urandom_range(1, 6);
      fill_pop();
      base = sq.size(); sbase = m_starts;
      pulse_start();
      wait_done("rand");
      finish_checks("rand", base, sbase, N, N, 1'b0);
    end
    run_len = 4; hold = 1;

    // Evaluator hangs on individual 2: watchdog fault, two scores only.
    tab[0] = 6'd12; tab[1] = 6'd7; tab[2] = 6'd1; tab[3] = 6'd2;
    hang_idx = 2;
    base = sq.size(); sbase = m_starts;
    pulse_start();
    wait_done("hang");
    finish_checks("hang", base, sbase, 2, 3, 1'b1);
    repeat (5) @(negedge clk);
    check("hang_fault_held", fault, 1'b1);
    check("hang_best_held", best_error, 6'd7);
    hang_idx = -1;
    repeat (2) @(negedge clk);
    base = sq.size(); sbase = m_starts;
    pulse_start();
    check("fault_clear_on_start", fault, 1'b0);
    wait_done("after_hang");
    finish_checks("after_hang", base, sbase, N, N, 1'b0);

    // Reset during RUN of individual 1.
    tab[0] = 6'd9; tab[1] = 6'd4; tab[2] = 6'd6; tab[3] = 6'd5;
    base = sq.size();
    pulse_start();
    c = 0;
    while (!(sq.size() > base && fit_buzy === 1'b1) && c < 500) begin @(negedge clk); c++; end
    check("midrst_reach_run", fit_buzy, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_buzy", buzy, 1'b0);
    check("midrst_fit_start", fit_start, 1'b0);
    check("midrst_best_error", best_error, 6'h3f);
    check("midrst_best_index", best_index, '0);
    check("midrst_total", total_error, '0);
    check("midrst_fit_individual", fit_individual, '0);
    check("midrst_err_addr", err_addr, '0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_no_more_writes", sq.size() - base, 1);
    base = sq.size(); sbase = m_starts;
    pulse_start();
    wait_done("post_rst");
    finish_checks("post_rst", base, sbase, N, N, 1'b0);

    // start pulsed during RUN is ignored.
    base = sq.size(); sbase = m_starts;
    pulse_start();
    c = 0;
    while (fit_buzy !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("ignore");
    finish_checks("ignore", base, sbase, N, N, 1'b0);
    busy_seen = 0;
    repeat (20) begin @(negedge clk); if (buzy !== 1'b0) busy_seen++; end
    check("ignore_no_relaunch", busy_seen, 0);

    // start held high: back-to-back runs, best re-initialised.
    tab[0] = 6'd8; tab[1] = 6'd3; tab[2] = 6'd3; tab[3] = 6'd11;
    base = sq.size(); sbase = m_starts;
    @(negedge clk); start = 1'b1;
    wait_done("held1");
    finish_checks("held1", base, sbase, N, N, 1'b0);
    base = sq.size(); sbase = m_starts;
    @(negedge clk);
    check("held_relaunch_buzy", buzy, 1'b1);
    check("held_best_reinit", best_error, 6'h3f);
    check("held_total_reinit", total_error, '0);
    start = 1'b0;
    wait_done("held2");
    finish_checks("held2", base, sbase, N, N, 1'b0);

    check("genome_matches_pop", gen_bad, 0);
    check("no_start_during_finish_pos", viol_p, 0);
    check("no_start_during_finish_neg", viol_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/population_fitness_scheduler.md
Name: population_fitness_scheduler

Overview:
Sequences one shared MorphologicFitness evaluator across a whole population of individuals. For each individual it fetches the genome from a population RAM, hands it to the evaluator, and waits for the evaluator's finish. It then writes the error to a score RAM and keeps a running best (minimum error) and total error. It sits between the GA top-level controller and the fitness datapath, so selection and crossover logic only see one start/done handshake per generation.

Parameters:
PopulationSize, 16, number of individuals evaluated per run (>=2)
IndexWidth, $clog2(PopulationSize), width of individual index/address
InstructionWidth, 64, genome width (matches fitness unit individual input)
ErrorWidth, 6, width of per-individual error from fitness unit
TotalWidth, ErrorWidth+IndexWidth, width of accumulated error
WatchdogWidth, 8, width of per-evaluation timeout counter; timeout = 2**WatchdogWidth-1 cycles

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  request a population evaluation; sampled only in IDLE
buzy  out  1  high from leaving IDLE until DONE is exited
done  out  1  one-cycle pulse in DONE
fault  out  1  watchdog expired during this run; held until next accepted start
pop_addr  out  IndexWidth  population RAM read address
pop_rd  out  1  population RAM read enable; data valid exactly 1 cycle later
pop_data  in  InstructionWidth  population RAM read data
fit_individual  out  InstructionWidth  registered genome driven to fitness unit
fit_start  out  1  start request to fitness unit
fit_buzy  in  1  fitness unit busy
fit_finish  in  1  fitness unit finish
fit_error  in  ErrorWidth  fitness unit error, valid while fit_finish high
err_we  out  1  score RAM write strobe, one cycle per individual
err_addr  out  IndexWidth  score RAM write address (= individual index)
err_data  out  ErrorWidth  error written
best_index  out  IndexWidth  index of lowest error so far
best_error  out  ErrorWidth  lowest error so far
total_error  out  TotalWidth  sum of all errors this run

Behaviour:
- Reset: state IDLE. All outputs 0, except best_error, which resets to all-ones. Index counter and watchdog reset to 0.
- IDLE: when start=1, clear fault, total_error, best_index and index. Set best_error to all-ones and move to FETCH. buzy=1 from the next cycle.
- FETCH: pop_rd=1 and pop_addr=index for one cycle, then LOAD.
- LOAD: register pop_data into fit_individual, clear watchdog, then LAUNCH.
- LAUNCH: hold fit_start=1 until fit_buzy=1 is sampled, then drop fit_start and go to RUN. fit_individual stays stable from LOAD until STORE exits.
- RUN: wait for fit_finish=1 and capture fit_error. The fitness unit changes state on negedge; sampling at posedge is required.
- Watchdog in LAUNCH and RUN: the counter increments each cycle. At all-ones, set fault=1, drop fit_start and go to DONE without writing a score.
- STORE (1 cycle):
  - err_we=1, err_addr=index, err_data=captured error.
  - total_error += error, zero-extended, no overflow possible at defaults.
  - If error < best_error (strictly less), update best_error and best_index; ties keep the lower index.
  - If index == PopulationSize-1, go to DONE; else index+1 and go to FETCH (no wrap).
- DONE: done=1 for exactly one cycle, buzy=0 on the following cycle, return to IDLE.
- best_*, total_error and fault hold after DONE until the next accepted start.
- start while not IDLE is ignored.
- start held high continuously re-launches a run directly after DONE returns to IDLE.
- rst asserted mid-run aborts immediately to reset values. fit_start drops on the same edge, and no further err_we is issued.
- Latency per individual: 1 (FETCH) + 1 (LOAD) + launch handshake + evaluator run + 1 (STORE).
- Only one fit_start per individual. fit_start never asserts while fit_finish=1 from the previous individual is still high. LAUNCH therefore waits for fit_finish=0 before asserting fit_start.

Decomposition:
- Shared GA package: state encoding localparams (IDLE, FETCH, LOAD, LAUNCH, RUN, STORE, DONE), the best_error reset constant (all-ones), and the default ErrorWidth/InstructionWidth.
- Natural sub-module: ga_best_tracker, containing the compare/update for best_index, best_error and total_error with a clear and an update enable.
- The FSM, index counter and watchdog stay in the top module.

Test Plan:
- PopulationSize=4, errors {5,3,7,3} from a behavioural fitness model (fixed 4-cycle run) -> err_we x4 at addr 0..3 with the same data; best_index=1, best_error=3, total_error=18; one done pulse, buzy falls the next cycle.
- All errors 0 -> best_index=0, best_error=0, total_error=0; each individual's fit_individual matches pop RAM word [i].
- Model never raises fit_finish on individual 2 -> fault=1 after 255 cycles in LAUNCH/RUN, err_we only for addr 0,1, done pulses, buzy drops.
- rst pulsed during RUN of individual 1 -> all outputs at reset values next cycle; fit_start=0; no err_we afterward; a fresh start evaluates from index 0.
- start pulsed during RUN -> ignored, exactly PopulationSize err_we strobes. start held high -> second run begins after DONE, with best_error re-initialised to all-ones.
- Model holds fit_finish high for 2 cycles -> one STORE per individual; next fit_start is not asserted until fit_finish=0.
